// File: rtl/dvp_rgb565_tx.sv
// DVP camera-side transmitter: serialises RGB565 pixels into OV5640-style
// vsync / href / byte-bus timing, high byte first, in the pclk domain.
module dvp_rgb565_tx #(
    parameter logic [12:0] H_ACTIVE = 13'd640,
    parameter logic [12:0] V_ACTIVE = 13'd480,
    parameter logic [15:0] H_BLANK  = 16'd64,
    parameter logic [15:0] VS_LEN   = 16'd16,
    parameter logic [15:0] V_BACK   = 16'd32,
    parameter logic [15:0] V_FRONT  = 16'd32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_en,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic [7:0]  cam_data,
    output logic        frame_start,
    output logic        frame_done,
    output logic        underflow,
    input  logic        underflow_clr
);

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        LINE,
        HBLANK,
        VFRONT
    } state_t;

    localparam logic [15:0] VS_LAST    = VS_LEN - 16'd1;
    localparam logic [15:0] VB_LAST    = V_BACK - 16'd1;
    localparam logic [15:0] LINE_LAST  = {2'b00, H_ACTIVE, 1'b0} - 16'd1;
    localparam logic [15:0] HB_LAST    = H_BLANK - 16'd1;
    localparam logic [15:0] VF_LAST    = V_FRONT - 16'd1;
    localparam logic [15:0] LINES_LAST = {3'b000, V_ACTIVE} - 16'd1;

    state_t      state;
    state_t      state_next;
    logic [15:0] cnt;
    logic [15:0] line_cnt;
    logic [7:0]  hold;
    logic        cnt_last;
    logic        more_lines;

    always_comb begin
        cnt_last = 1'b0;
        case (state)
            VSYNC:   cnt_last = (cnt == VS_LAST);
            VBACK:   cnt_last = (cnt == VB_LAST);
            LINE:    cnt_last = (cnt == LINE_LAST);
            HBLANK:  cnt_last = (cnt == HB_LAST);
            VFRONT:  cnt_last = (cnt == VF_LAST);
            default: cnt_last = 1'b0;
        endcase
    end

    assign more_lines = (line_cnt < LINES_LAST);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (tx_en) state_next = VSYNC;
            VSYNC:   if (cnt_last) state_next = VBACK;
            VBACK:   if (cnt_last) state_next = LINE;
            LINE:    if (cnt_last) state_next = HBLANK;
            HBLANK:  if (cnt_last) state_next = more_lines ? LINE : VFRONT;
            VFRONT:  if (cnt_last) state_next = tx_en ? VSYNC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Ready one clock ahead of each high-byte slot, so the fetched byte lands on the bus in time.
    assign pix_ready = ((state == VBACK) && cnt_last)
                     || ((state == HBLANK) && cnt_last && more_lines)
                     || ((state == LINE) && cnt[0] && !cnt_last);

    assign cam_vsync   = (state == VSYNC);
    assign cam_href    = (state == LINE);
    assign frame_start = (state == VSYNC) && (cnt == 16'd0);
    assign frame_done  = (state == VFRONT) && cnt_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 16'd0;
            line_cnt <= 16'd0;
        end else begin
            state <= state_next;
            if ((state_next != state) || (state == IDLE)) begin
                cnt <= 16'd0;
            end else begin
                cnt <= cnt + 16'd1;
            end
            if ((state == HBLANK) && cnt_last && more_lines) begin
                line_cnt <= line_cnt + 16'd1;
            end else if ((state != LINE) && (state != HBLANK)) begin
                line_cnt <= 16'd0;
            end
        end
    end

    // Starved fetches still occupy their slot with zero bytes so frame timing never moves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cam_data  <= 8'h00;
            hold      <= 8'h00;
            underflow <= 1'b0;
        end else begin
            if (pix_ready) begin
                if (pix_valid) begin
                    cam_data <= pix_data[15:8];
                    hold     <= pix_data[7:0];
                end else begin
                    cam_data <= 8'h00;
                    hold     <= 8'h00;
                end
            end else if ((state == LINE) && !cnt[0]) begin
                cam_data <= hold;
            end else begin
                cam_data <= 8'h00;
            end
            if (pix_ready && !pix_valid) begin
                underflow <= 1'b1;
            end else if (underflow_clr) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dvp_rgb565_tx.sv
// Self-checking bench for dvp_rgb565_tx: fixed-vector frame, then randomized
// frames checked against a frame-position arithmetic model.
module tb_dvp_rgb565_tx;

    localparam int H     = 4;
    localparam int V     = 3;
    localparam int HB    = 5;
    localparam int VSL   = 3;
    localparam int VB    = 2;
    localparam int VF    = 4;
    localparam int LL    = 2 * H + HB;
    localparam int ACT0  = VSL + VB;
    localparam int FRAME = VSL + VB + V * LL + VF;

    logic        clk;
    logic        rst;
    logic        tx_en;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_data;
    logic        frame_start;
    logic        frame_done;
    logic        underflow;
    logic        underflow_clr;

    int checks;
    int failures;
    bit uf;
    logic [15:0] sent [V * H];

    typedef struct {
        int         cyc;
        logic       vs;
        logic       href;
        logic       rdy;
        logic [7:0] data;
        logic       fs;
        logic       fd;
    } vec_t;

    vec_t vecs [18];

    dvp_rgb565_tx #(
        .H_ACTIVE(13'd4),
        .V_ACTIVE(13'd3),
        .H_BLANK (16'd5),
        .VS_LEN  (16'd3),
        .V_BACK  (16'd2),
        .V_FRONT (16'd4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_en        (tx_en),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .cam_vsync    (cam_vsync),
        .cam_href     (cam_href),
        .cam_data     (cam_data),
        .frame_start  (frame_start),
        .frame_done   (frame_done),
        .underflow    (underflow),
        .underflow_clr(underflow_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame position -> href slot: which pixel of the frame and which byte of it.
    function automatic bit in_slot(input int pos, output int k, output bit hi);
        int r;
        k  = 0;
        hi = 1'b0;
        if (pos < ACT0 || pos >= ACT0 + V * LL) return 1'b0;
        r = pos - ACT0;
        if (r % LL >= 2 * H) return 1'b0;
        k  = (r / LL) * H + (r % LL) / 2;
        hi = ((r % LL) % 2) == 0;
        return 1'b1;
    endfunction

    task automatic do_reset();
        rst           = 1'b1;
        tx_en         = 1'b0;
        pix_valid     = 1'b0;
        pix_data      = 16'h0000;
        underflow_clr = 1'b0;
        uf            = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic apply_stimulus(input int pos, input bit idle_tail, input int starve_k, input bit rand_mode);
        int  kn;
        bit  hi;
        bit  rdy;
        rdy           = !idle_tail && in_slot(pos + 1, kn, hi) && hi;
        pix_data      = 16'($urandom);
        pix_valid     = rand_mode ? ($urandom_range(0, 7) != 0) : !(rdy && kn == starve_k);
        underflow_clr = rand_mode ? ($urandom_range(0, 7) == 0) : 1'b0;
    endtask

    // Starts a frame from IDLE and checks every clock against the position model.
    task automatic run_model(input int nframes, input int starve_k, input bit drop_tx,
                             input bit rand_mode, output int hs);
        int         total;
        int         pos;
        int         k;
        int         kn;
        bit         hi;
        bit         hin;
        bit         hr;
        bit         rdy;
        bit         tail;
        logic [7:0] exp_d;
        total         = nframes * FRAME + (drop_tx ? 20 : 0);
        hs            = 0;
        pix_valid     = 1'b0;
        underflow_clr = 1'b0;
        tx_en         = 1'b1;
        @(posedge clk);
        #1;
        for (int g = 0; g < total; g++) begin
            pos  = g % FRAME;
            tail = (g / FRAME) >= nframes;
            apply_stimulus(pos, tail, starve_k, rand_mode);
            if (drop_tx && (g / FRAME) == nframes - 1 && pos == 35) tx_en = 1'b0;
            @(negedge clk);
            hr    = !tail && in_slot(pos, k, hi);
            rdy   = !tail && in_slot(pos + 1, kn, hin) && hin;
            exp_d = hr ? (hi ? sent[k][15:8] : sent[k][7:0]) : 8'h00;
            check_output("vsync", 16'(cam_vsync), 16'(!tail && pos < VSL));
            check_output("href", 16'(cam_href), 16'(hr));
            check_output("ready", 16'(pix_ready), 16'(rdy));
            check_output("data", 16'(cam_data), 16'(exp_d));
            check_output("frame_start", 16'(frame_start), 16'(!tail && pos == 0));
            check_output("frame_done", 16'(frame_done), 16'(!tail && pos == FRAME - 1));
            check_output("underflow", 16'(underflow), 16'(uf));
            if (rdy) sent[kn] = pix_valid ? pix_data : 16'h0000;
            if (pix_ready && pix_valid) hs++;
            uf = (rdy && !pix_valid) ? 1'b1 : (underflow_clr ? 1'b0 : uf);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int  nk;
        int  hs;
        bit  seen;
        checks   = 0;
        failures = 0;

        vecs[0]  = '{0,  1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1]  = '{2,  1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[2]  = '{3,  1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[3]  = '{4,  1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[4]  = '{5,  1'b0, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[5]  = '{6,  1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[6]  = '{7,  1'b0, 1'b1, 1'b0, 8'h03, 1'b0, 1'b0};
        vecs[7]  = '{12, 1'b0, 1'b1, 1'b0, 8'h06, 1'b0, 1'b0};
        vecs[8]  = '{13, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[9]  = '{17, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[10] = '{18, 1'b0, 1'b1, 1'b0, 8'h09, 1'b0, 1'b0};
        vecs[11] = '{25, 1'b0, 1'b1, 1'b0, 8'h0E, 1'b0, 1'b0};
        vecs[12] = '{30, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[13] = '{31, 1'b0, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0};
        vecs[14] = '{38, 1'b0, 1'b1, 1'b0, 8'h16, 1'b0, 1'b0};
        vecs[15] = '{43, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[16] = '{47, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[17] = '{48, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};

        do_reset();
        @(negedge clk);
        check_output("rst_vsync", 16'(cam_vsync), 16'h0);
        check_output("rst_href", 16'(cam_href), 16'h0);
        check_output("rst_data", 16'(cam_data), 16'h0);
        check_output("rst_ready", 16'(pix_ready), 16'h0);
        check_output("rst_fs", 16'(frame_start), 16'h0);
        check_output("rst_fd", 16'(frame_done), 16'h0);
        check_output("rst_underflow", 16'(underflow), 16'h0);

        // Fixed frame with incrementing pixels 0100, 0302, ...
        @(posedge clk);
        #1;
        nk        = 0;
        tx_en     = 1'b1;
        pix_valid = 1'b1;
        pix_data  = 16'h0100;
        @(posedge clk);
        #1;
        for (int c = 0; c <= FRAME; c++) begin
            @(negedge clk);
            foreach (vecs[i]) begin
                if (vecs[i].cyc == c) begin
                    check_output($sformatf("vec%0d_vsync", c), 16'(cam_vsync), 16'(vecs[i].vs));
                    check_output($sformatf("vec%0d_href", c), 16'(cam_href), 16'(vecs[i].href));
                    check_output($sformatf("vec%0d_ready", c), 16'(pix_ready), 16'(vecs[i].rdy));
                    check_output($sformatf("vec%0d_data", c), 16'(cam_data), 16'(vecs[i].data));
                    check_output($sformatf("vec%0d_fs", c), 16'(frame_start), 16'(vecs[i].fs));
                    check_output($sformatf("vec%0d_fd", c), 16'(frame_done), 16'(vecs[i].fd));
                end
            end
            if (pix_ready && pix_valid) nk++;
            @(posedge clk);
            #1;
            pix_data = {8'(2 * nk + 1), 8'(2 * nk)};
        end

        // Three back-to-back fully fed frames with random pixel data.
        do_reset();
        run_model(3, -1, 1'b0, 1'b0, hs);
        check_output("handshakes_3_frames", 16'(hs), 16'(3 * V * H));

        // Second pixel of line 1 starved, then sticky flag cleared.
        do_reset();
        run_model(1, 5, 1'b0, 1'b0, hs);
        underflow_clr = 1'b1;
        pix_valid     = 1'b1;
        @(negedge clk);
        check_output("underflow_sticky", 16'(underflow), 16'h1);
        @(posedge clk);
        #1 underflow_clr = 1'b0;
        @(negedge clk);
        check_output("underflow_cleared", 16'(underflow), 16'h0);

        // Random valid/clear, tx_en dropped in line 2 of the second frame, idle tail.
        do_reset();
        run_model(2, -1, 1'b1, 1'b1, hs);

        // Asynchronous reset in the middle of a line.
        do_reset();
        tx_en     = 1'b1;
        pix_valid = 1'b0;
        seen      = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (cam_href) begin
                seen = 1'b1;
                break;
            end
        end
        check_output("href_reached", 16'(seen), 16'h1);
        check_output("uf_before_rst", 16'(underflow), 16'h1);
        pix_valid = 1'b1;
        pix_data  = 16'hABCD;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check_output("data_before_rst", 16'(cam_data), 16'h00AB);
        #2 rst = 1'b1;
        #1;
        check_output("arst_href", 16'(cam_href), 16'h0);
        check_output("arst_vsync", 16'(cam_vsync), 16'h0);
        check_output("arst_data", 16'(cam_data), 16'h0);
        check_output("arst_ready", 16'(pix_ready), 16'h0);
        check_output("arst_underflow", 16'(underflow), 16'h0);
        tx_en     = 1'b0;
        pix_valid = 1'b0;
        uf        = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        run_model(1, -1, 1'b0, 1'b0, hs);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
